// File: rtl/fifo.sv
// Single-clock FIFO with registered read data.
// Flags decode the occupancy counter; push_ptr is exported for debug.
module fifo #(
  parameter int width  = 4,
  parameter int length = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic                         pop,
  input  logic [width-1:0]             data,
  output logic [$clog2(length-1)-1:0]  push_ptr,
  output logic                         full,
  output logic                         empty,
  output logic [width-1:0]             out
);

  localparam int aw = $clog2(length-1);
  localparam int cw = $clog2(length)+1;

  localparam logic [aw-1:0] ptr_one = aw'(1);
  localparam logic [cw-1:0] cnt_one = cw'(1);
  localparam logic [cw-1:0] cnt_max = cw'(length);

  logic [width-1:0] mem [length];
  logic [aw-1:0]    pop_ptr;
  logic [cw-1:0]    count;

  logic push_ok;
  logic pop_ok;

  assign full  = (count == cnt_max);
  assign empty = (count == '0);

  // A pop frees a slot in the same edge, so push is allowed at full.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage is intentionally left uncleared by reset.
  always_ff @(posedge clk) begin
    if (!rstn && push_ok) begin
      mem[push_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      push_ptr <= '0;
    end else if (push_ok) begin
      push_ptr <= push_ptr + ptr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      pop_ptr <= '0;
      out     <= '0;
    end else if (pop_ok) begin
      pop_ptr <= pop_ptr + ptr_one;
      out     <= mem[pop_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      count <= '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + cnt_one;
        2'b01:   count <= count - cnt_one;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: reset, fill, drain, simultaneous
// push/pop at full and empty, pointer wrap and mid-stream reset.
module tb_fifo;

  localparam int width  = 4;
  localparam int length = 4;

  logic             clk;
  logic             rstn;
  logic             push;
  logic             pop;
  logic [width-1:0] data;
  logic [1:0]       push_ptr;
  logic             full;
  logic             empty;
  logic [width-1:0] out;

  int checks;
  int failures;

  fifo #(
    .width (width),
    .length(length)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .pop     (pop),
    .data    (data),
    .push_ptr(push_ptr),
    .full    (full),
    .empty   (empty),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request set, clock it in, sample 1 time unit later.
  task automatic cyc(input logic r, input logic pu, input logic po,
                     input logic [width-1:0] d);
    rstn = r;
    push = pu;
    pop  = po;
    data = d;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    data = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    data = '0;
    @(negedge clk);

    // Reset then idle
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_ptr", 32'(push_ptr), 32'd0);

    // Fill
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 4'(i));
      chk("fill_ptr", 32'(push_ptr), 32'((i + 1) % 4));
      chk("fill_empty", 32'(empty), 32'd0);
      chk("fill_full", 32'(full), (i == 3) ? 32'd1 : 32'd0);
    end
    cyc(1'b0, 1'b1, 1'b0, 4'd4);
    chk("drop_ptr", 32'(push_ptr), 32'd0);
    chk("drop_full", 32'(full), 32'd1);
    chk("drop_cnt", 32'(dut.count), 32'd4);

    // Drain
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 4'd0);
      chk("drain_out", 32'(out), (i > 3) ? 32'd3 : 32'(i));
      chk("drain_empty", 32'(empty), (i >= 3) ? 32'd1 : 32'd0);
      chk("drain_full", 32'(full), 32'd0);
    end

    // Simultaneous push/pop at full
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 4'(i));
    chk("sf_pre_full", 32'(full), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 4'd9);
    chk("sf_out", 32'(out), 32'd0);
    chk("sf_full", 32'(full), 32'd1);
    chk("sf_ptr", 32'(push_ptr), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 4'd0);
    chk("sf_pop1", 32'(out), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 4'd0);
    chk("sf_pop2", 32'(out), 32'd2);
    cyc(1'b0, 1'b0, 1'b1, 4'd0);
    chk("sf_pop3", 32'(out), 32'd3);
    cyc(1'b0, 1'b0, 1'b1, 4'd0);
    chk("sf_pop4", 32'(out), 32'd9);
    chk("sf_empty", 32'(empty), 32'd1);

    // Simultaneous push/pop at empty: no bypass
    cyc(1'b0, 1'b1, 1'b1, 4'd5);
    chk("se_out", 32'(out), 32'd9);
    chk("se_cnt", 32'(dut.count), 32'd1);
    chk("se_empty", 32'(empty), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 4'd0);
    chk("se_pop", 32'(out), 32'd5);
    chk("se_empty2", 32'(empty), 32'd1);

    // Wrap: steady occupancy of 2 with both pointers cycling
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, (k >= 2), 4'((k + 6) % 16));
      if (k >= 2) chk("wrap_out", 32'(out), 32'((k + 4) % 16));
    end
    chk("wrap_cnt", 32'(dut.count), 32'd2);
    chk("wrap_ptr", 32'(push_ptr), 32'd0);

    // Mid-stream reset with requests on the reset edge
    cyc(1'b1, 1'b1, 1'b1, 4'd7);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_full", 32'(full), 32'd0);
    chk("mrst_ptr", 32'(push_ptr), 32'd0);
    chk("mrst_out", 32'(out), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 4'd0);
    chk("mrst_pop_empty", 32'(out), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 4'd12);
    chk("post_ptr", 32'(push_ptr), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 4'd0);
    chk("post_out", 32'(out), 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
